// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, in-order instruction FIFO, redirect flush.
// Latency: request accept -> memory latency -> +1 cycle until instr_valid.
// Backpressure: requests stop when in-flight plus buffered words reach DEPTH; decode stalls via instr_ready.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push_vld,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop_rdy,
    output logic                    head_vld,
    output logic [W-1:0]            head_dat,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign count    = wptr - rptr;
    assign head_vld = (count != '0);
    assign head_dat = mem[rptr[AW-1:0]];
    assign do_pop   = pop_rdy && head_vld;
    assign do_push  = push_vld && ((count != FULL) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [5:0]        opcode,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] redirect_target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_cnt;
    logic [CW:0]       inflight;
    logic              req_fire;
    logic              resp_keep;
    logic              head_vld;
    entry_t            push_dat;
    entry_t            head_dat;
    logic              unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];
    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Requests only go out while every possible return still has a FIFO slot.
    assign inflight       = {1'b0, outstanding} + {1'b0, fifo_cnt};
    assign imem_req_valid = !reset && !redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_keep     = imem_resp_valid && !redirect_valid && (drop_cnt == '0);
    assign push_dat.word = imem_resp_data;
    assign push_dat.pc   = resp_pc;

    fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (resp_keep),
        .push_dat (push_dat),
        .pop_rdy  (instr_ready),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (fifo_cnt)
    );

    assign instr_valid = head_vld;
    assign instr       = head_vld ? head_dat.word : '0;
    assign instr_pc    = head_vld ? head_dat.pc : '0;
    assign opcode      = head_vld ? head_dat.word[31:26] : 6'b000000;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight is wrong-path, including a response arriving now.
            pc          <= redirect_target;
            resp_pc     <= redirect_target;
            outstanding <= outstanding - CW'(imem_resp_valid);
            drop_cnt    <= outstanding - CW'(imem_resp_valid);
        end else begin
            if (req_fire)  pc      <= pc + ADDR_W'(4);
            if (resp_keep) resp_pc <= resp_pc + ADDR_W'(4);
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with an in-order memory model and an architectural stream model.
module tb_instr_fetch_unit;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  opcode;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .opcode(opcode),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_lo = 1;
    int lat_hi = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] exp_pc = RESET_PC;   // next instruction decode should receive
    logic [31:0] req_pc = RESET_PC;   // next address the fetcher should request

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h20010005;
        return (a * 32'h9E3779B1) ^ {a[15:0], 16'h5A5A};
    endfunction

    task automatic step(input bit rr, input bit ir, input bit rd, input logic [31:0] rpc,
                        output bit acc, output bit popd, output bit ivld, output bit rsp,
                        output logic [31:0] aaddr, output logic [31:0] ipc, output logic [5:0] opc);
        logic [31:0] w;
        imem_req_ready = rr;
        instr_ready    = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        acc = imem_req_valid && rr;
        popd = instr_valid && ir;
        ivld = instr_valid;
        rsp = imem_resp_valid;
        aaddr = imem_addr;
        ipc = instr_pc;
        opc = opcode;
        w = mem_word(exp_pc);
        if (instr_valid) begin
            checks += 3;
            if (instr_pc !== exp_pc) begin
                errors++; $display("FAIL head_pc cyc=%0d got %h want %h", cyc, instr_pc, exp_pc);
            end
            if (instr !== w) begin
                errors++; $display("FAIL head_word cyc=%0d got %h want %h", cyc, instr, w);
            end
            if (opcode !== w[31:26]) begin
                errors++; $display("FAIL opcode cyc=%0d got %b want %b", cyc, opcode, w[31:26]);
            end
        end else begin
            checks++;
            if (opcode !== 6'b0) begin
                errors++; $display("FAIL opcode_idle cyc=%0d got %b want 000000", cyc, opcode);
            end
        end
        if (imem_req_valid) begin
            checks++;
            if (imem_addr !== req_pc) begin
                errors++; $display("FAIL req_addr cyc=%0d got %h want %h", cyc, imem_addr, req_pc);
            end
        end
        if (rd) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++; $display("FAIL redirect_no_req cyc=%0d got %b want 0", cyc, imem_req_valid);
            end
        end
        checks++;
        assert (int'(dut.outstanding) + int'(dut.fifo_cnt) <= DEPTH && dut.drop_cnt <= dut.outstanding)
        else begin
            errors++;
            $display("FAIL counters cyc=%0d outstanding=%0d fifo=%0d drop=%0d limit %0d",
                     cyc, dut.outstanding, dut.fifo_cnt, dut.drop_cnt, DEPTH);
        end
        if (rsp) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (acc) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
        end
        if (popd) exp_pc += 32'd4;
        if (rd) begin
            exp_pc = {rpc[31:2], 2'b00};
            req_pc = {rpc[31:2], 2'b00};
        end else if (acc) begin
            req_pc += 32'd4;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        imem_req_ready = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
        imem_resp_valid = 1'b0; redirect_pc = '0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks += 6;
        if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", imem_req_valid); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b want 0", instr_valid); end
        if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instr); end
        if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h want 0", instr_pc); end
        if (opcode !== 6'h0) begin errors++; $display("FAIL rst_opcode got %b want 0", opcode); end
        if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rst_pc got %h want %h", imem_addr, RESET_PC); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        exp_pc = RESET_PC;
        req_pc = RESET_PC;
    endtask

    task automatic test_stream();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        int fa = -1, fv = -1, na = 0;
        logic [5:0] first_opc = '0;
        test_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            if (acc) begin
                if (fa < 0) fa = i;
                if (na < 3) begin
                    checks++;
                    if (aa !== RESET_PC + 32'(4 * na)) begin
                        errors++; $display("FAIL stream_addr%0d got %h want %h", na, aa, RESET_PC + 32'(4 * na));
                    end
                end
                na++;
            end
            if (ivld && fv < 0) begin fv = i; first_opc = opc; end
        end
        checks += 2;
        if (fv - fa != 2) begin errors++; $display("FAIL stream_latency got %0d want 2", fv - fa); end
        if (first_opc !== 6'b001000) begin errors++; $display("FAIL stream_opcode got %b want 001000", first_opc); end
    endtask

    task automatic test_backpressure();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        int na = 0, np = 0;
        bit got = 0;
        test_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            if (acc) na++;
        end
        checks += 3;
        if (na != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", na); end
        if (acc) begin errors++; $display("FAIL bp_req_valid got 1 want 0"); end
        if (!ivld || ipc !== RESET_PC) begin errors++; $display("FAIL bp_head got v=%b pc=%h want v=1 pc=%h", ivld, ipc, RESET_PC); end
        for (int i = 0; i < 10 && !got; i++) begin
            step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            if (popd && np < 2) begin
                checks++;
                if (ipc !== RESET_PC + 32'(4 * np)) begin
                    errors++; $display("FAIL bp_drain%0d got %h want %h", np, ipc, RESET_PC + 32'(4 * np));
                end
                np++;
            end
            if (acc) begin
                got = 1;
                checks++;
                if (aa !== RESET_PC + 32'd8) begin errors++; $display("FAIL bp_resume got %h want %h", aa, RESET_PC + 32'd8); end
            end
        end
        checks++;
        if (!got || np != 2) begin errors++; $display("FAIL bp_timeout got resume=%0d pops=%0d want 1/2", got, np); end
    endtask

    task automatic test_req_stall();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        test_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            checks += 2;
            if (aa !== RESET_PC) begin errors++; $display("FAIL stall_addr got %h want %h", aa, RESET_PC); end
            if (ivld) begin errors++; $display("FAIL stall_instr_valid got 1 want 0"); end
        end
        step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        checks++;
        if (!acc || aa !== RESET_PC) begin errors++; $display("FAIL stall_release got acc=%b addr=%h want 1/%h", acc, aa, RESET_PC); end
    endtask

    task automatic test_redirect_inflight();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        bit got_acc = 0, got_pop = 0;
        test_reset();
        lat_lo = 4; lat_hi = 4;
        step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        checks++;
        if (mq_addr.size() != 2) begin errors++; $display("FAIL rdi_inflight got %0d want 2", mq_addr.size()); end
        step(1, 1, 1, 32'h0000_0103, acc, popd, ivld, rsp, aa, ipc, opc);
        for (int i = 0; i < 40 && !got_pop; i++) begin
            step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            if (acc && !got_acc) begin
                got_acc = 1;
                checks++;
                if (aa !== 32'h100) begin errors++; $display("FAIL rdi_addr got %h want 00000100", aa); end
            end
            if (popd) begin
                got_pop = 1;
                checks++;
                if (ipc !== 32'h100) begin errors++; $display("FAIL rdi_first_pc got %h want 00000100", ipc); end
            end
        end
        checks++;
        if (!got_pop) begin errors++; $display("FAIL rdi_timeout got no delivery want one"); end
    endtask

    task automatic test_redirect_pop_resp();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        bit got = 0;
        test_reset();
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        step(1, 0, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        step(1, 1, 1, 32'h0000_0200, acc, popd, ivld, rsp, aa, ipc, opc);
        checks++;
        if (!popd || !rsp || ipc !== RESET_PC) begin
            errors++; $display("FAIL rpr_setup got pop=%b rsp=%b pc=%h want 1/1/%h", popd, rsp, ipc, RESET_PC);
        end
        step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        checks++;
        if (ivld) begin errors++; $display("FAIL rpr_flushed got instr_valid=1 want 0"); end
        for (int i = 0; i < 20 && !got; i++) begin
            step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            if (popd) begin
                got = 1;
                checks++;
                if (ipc !== 32'h200) begin errors++; $display("FAIL rpr_first_pc got %h want 00000200", ipc); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL rpr_timeout got no delivery want one"); end
    endtask

    task automatic test_reset_midstream();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        bit got = 0, got_acc = 0;
        test_reset();
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 6; i++) step(1, 0, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
        checks++;
        if (!ivld) begin errors++; $display("FAIL mid_full got instr_valid=0 want 1"); end
        test_reset();
        for (int i = 0; i < 20 && !got; i++) begin
            step(1, 1, 0, '0, acc, popd, ivld, rsp, aa, ipc, opc);
            if (acc && !got_acc) begin
                got_acc = 1;
                checks++;
                if (aa !== RESET_PC) begin errors++; $display("FAIL mid_restart got %h want %h", aa, RESET_PC); end
            end
            if (popd) begin
                got = 1;
                checks++;
                if (ipc !== RESET_PC) begin errors++; $display("FAIL mid_first_pc got %h want %h", ipc, RESET_PC); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL mid_timeout got no delivery want one"); end
    endtask

    task automatic test_random();
        bit acc, popd, ivld, rsp;
        logic [31:0] aa, ipc;
        logic [5:0] opc;
        int pops = 0;
        test_reset();
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
                 $urandom, acc, popd, ivld, rsp, aa, ipc, opc);
            if (popd) pops++;
        end
        checks++;
        if (pops < 150) begin errors++; $display("FAIL rand_progress got %0d pops want >=150", pops); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_inflight();
        test_redirect_pop_resp();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the opcode/control interface. Generates the instruction stream whose opcode field feeds the main control decoder.
- Holds the PC and issues word-aligned requests to instruction memory over a valid/ready request channel.
- Buffers returned words in a small in-order FIFO and presents them to decode with a valid/ready handshake.
- Accepts jump/branch redirects from execute and discards wrong-path words.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 0, PC value loaded by reset (bits [1:0] must be 0).
- DEPTH, 2, instruction FIFO entries; also the maximum of in-flight requests plus buffered words (power of two, at least 2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  ADDR_W  fetch address (current PC).
- imem_resp_valid  in  1  returned instruction valid; exactly one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  returned instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  32  FIFO head word.
- instr_pc  out  ADDR_W  address of head word.
- opcode  out  6  instr[31:26] when instr_valid, else 6'b000000.
- redirect_valid  in  1  jump/branch taken.
- redirect_pc  in  ADDR_W  target; bits [1:0] ignored, treated as 00.

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty. imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, opcode=0 in the cycle after reset is sampled. The environment resets memory with the same reset; no responses to pre-reset requests arrive after reset.
- Credit rule: imem_req_valid=1 iff !redirect_valid and (outstanding + fifo_count) < DEPTH. This guarantees the FIFO never overflows.
- imem_addr=pc whenever imem_req_valid=1. The address is held stable while valid=1 and ready=0.
- Request accept (valid&&ready): pc <= pc+4 (wraps mod 2^ADDR_W), outstanding++.
- Response with drop_cnt==0: push {imem_resp_data, address} into the FIFO, outstanding--. The per-entry PC is tracked by a response-address counter that advances by 4 per kept response.
- Response with drop_cnt>0: discard the word, drop_cnt--, outstanding--.
- Pop: instr_valid&&instr_ready removes the head. Push and pop in the same cycle are legal at any occupancy, including full and empty-with-bypass-disabled. A pushed word becomes visible at the head no earlier than the next cycle (latency: accept -> memory latency -> +1 cycle to instr_valid).
- Redirect cycle (redirect_valid=1):
  - FIFO flushed after any same-cycle pop completes; the popped word counts as consumed.
  - pc <= {redirect_pc[ADDR_W-1:2],2'b00}, and the response-address counter is set to the same value.
  - drop_cnt <= outstanding minus (1 if a response arrives this cycle); that response is itself discarded.
  - No request is issued this cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each cycle.
- Order of precedence each cycle: reset > redirect > normal push/pop/issue.
- Counters: outstanding and drop_cnt are clog2(DEPTH)+1 bits and never exceed DEPTH. An underflow is a protocol violation, flagged by a bench assertion.

Test Plan:
- Reset, then imem_req_ready=1, 1-cycle memory, instr_ready=1 -> addresses 0x0,0x4,0x8…; instr_valid first high 2 cycles after first accept; opcode tracks word[31:26] (e.g. 0x20010005 -> opcode 6'b001000).
- instr_ready=0 with DEPTH=2 -> exactly 2 requests accepted, imem_req_valid stays 0, FIFO holds 0x0/0x4; raising instr_ready drains both in order and issue resumes at 0x8.
- imem_req_ready=0 for 5 cycles -> imem_addr held at the same PC, no pc advance, instr_valid=0.
- Redirect to 0x0000_0103 with 2 requests in flight -> both responses dropped, next request address 0x100, first delivered instr_pc=0x100.
- Redirect coinciding with a response and a pop -> popped word delivered once, arriving word discarded, FIFO empty next cycle.
- Reset asserted mid-stream with full FIFO -> next cycle all outputs 0, pc=RESET_PC, fetching restarts from RESET_PC.
